// File: rtl/sha256_core.sv
// rtl/sha256_core.sv - SHA-256 compression engine, 1/2/4 rounds per clock, rolling 16-word schedule
// Optional double SHA-256 second pass when SHA_DOUBLE_EN is defined.
module sha256_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         use_midstate,
  input  logic [255:0] midstate_in,
  input  logic         double_hash,
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] LAST_CNT = 6'(64 - R);
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
    $error("sha256_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q;
  logic [31:0]  st_q [8];
  logic [31:0]  hb_q [8];
  logic [31:0]  w_q [16];
  logic [255:0] digest_q;
  logic         done_q;
  logic         accept;
  logic         second_pass;
  logic [31:0]  base [8];
  logic [31:0]  ext [16+R];
  logic [31:0]  v [8];
  logic [31:0]  t1, t2;
  logic [255:0] fin_vec;

`ifdef SHA_DOUBLE_EN
  logic dbl_q;
  assign second_pass = dbl_q;
`else
  logic unused_double;
  assign unused_double = double_hash;
  assign second_pass   = 1'b0;
`endif

  // ready stays low through the done cycle so a start there is dropped
  assign ready  = (state_q == IDLE) && !done_q;
  assign accept = start && ready;
  assign done   = done_q;
  assign digest = digest_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      base[i] = use_midstate ? midstate_in[255-32*i -: 32] : IV[255-32*i -: 32];
    end
  end

  // Window always holds W[t..t+15]; ext appends the R words that shift in next
  always_comb begin
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < R; j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
    for (int i = 0; i < 8; i++) v[i] = st_q[i];
    for (int j = 0; j < R; j++) begin
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[cnt_q + 6'(j)] + ext[j];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6];
      v[6] = v[5];
      v[5] = v[4];
      v[4] = v[3] + t1;
      v[3] = v[2];
      v[2] = v[1];
      v[1] = v[0];
      v[0] = t1 + t2;
    end
  end

  always_comb begin
    fin_vec = '0;
    for (int i = 0; i < 8; i++) fin_vec[255-32*i -: 32] = hb_q[i] + st_q[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (cnt_q == LAST_CNT) state_d = FINAL;
      FINAL:   state_d = second_pass ? ROUND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        st_q[i] <= '0;
        hb_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
`ifdef SHA_DOUBLE_EN
      dbl_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) w_q[i] <= block_in[511-32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              st_q[i] <= base[i];
              hb_q[i] <= base[i];
            end
            cnt_q <= '0;
`ifdef SHA_DOUBLE_EN
            dbl_q <= double_hash;
`endif
          end
        end
        ROUND: begin
          for (int i = 0; i < 8; i++) st_q[i] <= v[i];
          for (int i = 0; i < 16; i++) w_q[i] <= ext[i+R];
          cnt_q <= cnt_q + 6'(R);
        end
        FINAL: begin
`ifdef SHA_DOUBLE_EN
          // Second pass hashes the 256-bit first digest as a single padded block
          if (dbl_q) begin
            dbl_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
              w_q[i]  <= fin_vec[255-32*i -: 32];
              st_q[i] <= IV[255-32*i -: 32];
              hb_q[i] <= IV[255-32*i -: 32];
            end
            w_q[8] <= 32'h80000000;
            for (int i = 9; i < 15; i++) w_q[i] <= '0;
            w_q[15] <= 32'h00000100;
          end else
`endif
          begin
            digest_q <= fin_vec;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// tb/tb_sha256_core.sv - directed-vector bench for sha256_core at 1, 2 and 4 rounds per clock
module tb_sha256_core;
  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] H1 =
    256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] EXP_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EXP_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] EXP_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] EXP_DBL =
    256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [511:0] block_in;
  logic         use_midstate;
  logic [255:0] midstate_in;
  logic         double_hash;
  logic         ready, done;
  logic [255:0] digest;
  logic         ready2, done2, ready4, done4;
  logic [255:0] digest2, digest4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sha256_core #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .block_in(block_in),
    .use_midstate(use_midstate), .midstate_in(midstate_in), .double_hash(double_hash),
    .ready(ready), .done(done), .digest(digest)
  );

  sha256_core #(.ROUNDS_PER_CYCLE(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .start(start), .block_in(block_in),
    .use_midstate(use_midstate), .midstate_in(midstate_in), .double_hash(double_hash),
    .ready(ready2), .done(done2), .digest(digest2)
  );

  sha256_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .start(start), .block_in(block_in),
    .use_midstate(use_midstate), .midstate_in(midstate_in), .double_hash(double_hash),
    .ready(ready4), .done(done4), .digest(digest4)
  );

  typedef struct {
    logic [511:0] blk;
    logic         use_mid;
    logic [255:0] mid;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic run_block(input logic [511:0] blk, input logic um, input logic [255:0] mid,
                           input logic dh, output int lat, output logic [255:0] dig,
                           output logic rdy_at_done);
    wait_ready();
    block_in     = blk;
    use_midstate = um;
    midstate_in  = mid;
    double_hash  = dh;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!done && lat < 300);
    dig         = digest;
    rdy_at_done = ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, lat2, lat4, ndone;
    logic [255:0] dig, dig2, dig4;
    logic         rdy;

    n_rst = 1'b0; start = 1'b0; block_in = '0; use_midstate = 1'b0;
    midstate_in = '0; double_hash = 1'b0;

    vecs[0] = '{ABC,   1'b0, '0,                                                 EXP_ABC};
    vecs[1] = '{EMPTY, 1'b0, '0,                                                 EXP_EMPTY};
    vecs[2] = '{B1,    1'b0, '0,                                                 H1};
    vecs[3] = '{B2,    1'b1, H1,                                                 EXP_TWO};
    vecs[4] = '{ABC,   1'b0, 256'hdeadbeef_01234567_89abcdef_55aa55aa_0f0f0f0f_ffffffff_00000001_80000000, EXP_ABC};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", ready, 1'b1);
    chk("reset_done", done, 1'b0);
    chk("reset_digest", digest, '0);
    n_rst = 1'b1;

    // Empty message on all three widths at once: latency 65/33/17
    @(negedge clk);
    block_in = EMPTY; use_midstate = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; lat2 = 0; lat4 = 0; dig = '0; dig2 = '0; dig4 = '0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done && lat == 0) begin lat = c; dig = digest; end
      if (done2 && lat2 == 0) begin lat2 = c; dig2 = digest2; end
      if (done4 && lat4 == 0) begin lat4 = c; dig4 = digest4; end
    end
    chk("r1_empty_latency", 256'(lat), 256'(65));
    chk("r2_empty_latency", 256'(lat2), 256'(33));
    chk("r4_empty_latency", 256'(lat4), 256'(17));
    chk("r1_empty_digest", dig, EXP_EMPTY);
    chk("r2_empty_digest", dig2, EXP_EMPTY);
    chk("r4_empty_digest", dig4, EXP_EMPTY);

    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i].blk, vecs[i].use_mid, vecs[i].mid, 1'b0, lat, dig, rdy);
      chk($sformatf("vec%0d_digest", i), dig, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(65));
      chk($sformatf("vec%0d_ready_at_done", i), rdy, 1'b0);
    end

    // start held high across a whole run while block_in changes after accept
    wait_ready();
    block_in = ABC; use_midstate = 1'b0; double_hash = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_accepted", ready, 1'b0);
    block_in = EMPTY;
    ndone = 0; lat = 0; dig = '0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        lat = c;
        dig = digest;
        chk("hold_ready_in_done", ready, 1'b0);
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("hold_done_count", 256'(ndone), 256'(1));
    chk("hold_latency", 256'(lat), 256'(65));
    chk("hold_digest", dig, EXP_ABC);
    chk("hold_digest_held", digest, EXP_ABC);
    chk("hold_ready_back", ready, 1'b1);
    run_block(EMPTY, 1'b0, '0, 1'b0, lat, dig, rdy);
    chk("hold_next_digest", dig, EXP_EMPTY);

    // Asynchronous abort around round 30
    wait_ready();
    block_in = ABC; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_digest", digest, '0);
    @(negedge clk);
    n_rst = 1'b1;
    ndone = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 256'(ndone), 256'(0));
    run_block(ABC, 1'b0, '0, 1'b0, lat, dig, rdy);
    chk("abort_rerun_digest", dig, EXP_ABC);
    chk("abort_rerun_latency", 256'(lat), 256'(65));

    // double_hash request: honoured only when the second pass is built in
    run_block(ABC, 1'b0, '0, 1'b1, lat, dig, rdy);
    chk("dbl_done_seen", 256'(lat < 300), 256'(1));
`ifdef SHA_DOUBLE_EN
    chk("dbl_digest", dig, EXP_DBL);
`else
    chk("dbl_digest", dig, EXP_ABC);
    chk("dbl_latency", 256'(lat), 256'(65));
`endif
    double_hash = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
